snn: RTL and testbench

Top-level spiking-neural-network classifier for 28x28 binary images. It receives one image as 98 bytes over a UART link and integrates one timestep of 10 output neurons against a stored weight ROM. It shows the winning digit on `led` and reports the digit back over UART as an ASCII character. It sits between the host-side UART pair and the board LEDs.

---
 rtl/snn_pkg.sv | 35 +++
 rtl/snn_weight_rom.sv | 24 ++
 rtl/snn.sv | 203 ++++++++++++++++++++
 tb/tb_snn.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared constants, state encoding and saturating accumulate helper for the SNN classifier.
// Pure declarations, no latency.
// No flow control; consumers decide when to apply the helper.
package snn_pkg;

    localparam int NUM_PIXELS  = 784;
    localparam int NUM_BYTES   = 98;
    localparam int NUM_NEURONS = 10;
    localparam int W_WIDTH     = 8;
    localparam int POT_WIDTH   = 16;
    localparam int PIX_W       = 10;
    localparam int BYTE_CNT_W  = 7;
    localparam int ROM_W       = NUM_NEURONS * W_WIDTH;

    typedef enum logic [1:0] {
        ST_RECV,
        ST_INFER,
        ST_DECIDE,
        ST_SEND
    } snn_state_t;

    // Signed potential plus signed weight, clamped to the potential range.
    function automatic logic signed [POT_WIDTH-1:0] sat_add(
        input logic signed [POT_WIDTH-1:0] a,
        input logic signed [W_WIDTH-1:0]   w
    );
        logic signed [POT_WIDTH:0] s;
        s = {a[POT_WIDTH-1], a} + {{(POT_WIDTH + 1 - W_WIDTH){w[W_WIDTH-1]}}, w};
        if (s[POT_WIDTH] != s[POT_WIDTH-1]) begin
            return s[POT_WIDTH] ? {1'b1, {(POT_WIDTH-1){1'b0}}} : {1'b0, {(POT_WIDTH-1){1'b1}}};
        end
        return s[POT_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/snn_weight_rom.sv
// Weight ROM: one 80-bit word (ten signed 8-bit weights) per pixel.
// 1-cycle registered read; caller presents the address one cycle ahead.
// No backpressure; a new address is accepted every cycle.
module snn_weight_rom
    import snn_pkg::*;
#(
    parameter string WEIGHT_FILE = "snn_weights.hex"
) (
    input  logic             clk,
    input  logic [PIX_W-1:0] addr_i,
    output logic [ROM_W-1:0] data_o
);

    logic [ROM_W-1:0] rom_mem [NUM_PIXELS];
    logic [ROM_W-1:0] data_q;

    // Synchronous read port.
    always_ff @(posedge clk) begin
        data_q <= rom_mem[addr_i];
    end

    assign data_o = data_q;

endmodule

// File: rtl/snn.sv
// SNN classifier: receives a 784-pixel binary image over UART, integrates 10 neurons, reports argmax.
// Result 786 cycles after the stop sample of the last image byte (INFER 784 + DECIDE 1 + RX handoff 1).
// No backpressure on UART: bytes completing outside RECV or with a bad stop bit are dropped.
module snn
    import snn_pkg::*;
#(
    parameter int    CLKS_PER_BIT = 868,
    parameter string WEIGHT_FILE  = "snn_weights.hex"
) (
    input  logic       clk,
    input  logic       sys_rst_n,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic [7:0] led
);

    localparam logic [15:0] BIT_CNT  = 16'(CLKS_PER_BIT);
    localparam logic [15:0] HALF_CNT = 16'(CLKS_PER_BIT / 2);

    // Active-high despite the name.
    logic rst;
    assign rst = sys_rst_n;

    logic rx_s1_q, rx_s2_q, rx_s3_q;
    logic rx_busy_q, rx_vld_q;
    logic [3:0] rx_bit_q;
    logic [15:0] rx_cnt_q;
    logic [7:0] rx_shift_q, rx_dat_q;

    snn_state_t state_q;
    logic [BYTE_CNT_W-1:0] byte_cnt_q;
    logic [NUM_PIXELS-1:0] img_q;
    logic [PIX_W-1:0] pix_q;
    logic signed [POT_WIDTH-1:0] pot_q [NUM_NEURONS];
    logic [7:0] led_q;

    logic tx_busy_q, tx_line_q;
    logic [15:0] tx_cnt_q;
    logic [3:0] tx_bits_q;
    logic [8:0] tx_frame_q;

    logic [PIX_W-1:0] rom_addr;
    logic [ROM_W-1:0] rom_data;
    logic [3:0] win_idx;
    logic signed [POT_WIDTH-1:0] win_pot;

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_s3_q <= 1'b1;
        end else begin
            rx_s1_q <= uart_rx;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
        end
    end

    // UART receiver: bit 0 is the start check, 1..8 data (LSB first), 9 the stop check.
    // The counter starts at 2 so the start sample lands HALF_CNT cycles after the synchronized edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_busy_q  <= 1'b0;
            rx_vld_q   <= 1'b0;
            rx_bit_q   <= '0;
            rx_cnt_q   <= '0;
            rx_shift_q <= '0;
            rx_dat_q   <= '0;
        end else begin
            rx_vld_q <= 1'b0;
            if (!rx_busy_q) begin
                if (rx_s3_q && !rx_s2_q) begin
                    rx_busy_q <= 1'b1;
                    rx_bit_q  <= '0;
                    rx_cnt_q  <= 16'd2;
                end
            end else if ((rx_bit_q == 4'd0 && rx_cnt_q == HALF_CNT) ||
                         (rx_bit_q != 4'd0 && rx_cnt_q == BIT_CNT)) begin
                rx_cnt_q <= 16'd1;
                rx_bit_q <= rx_bit_q + 4'd1;
                if (rx_bit_q == 4'd0) begin
                    if (rx_s2_q) rx_busy_q <= 1'b0;
                end else if (rx_bit_q <= 4'd8) begin
                    rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
                end else begin
                    rx_busy_q <= 1'b0;
                    if (rx_s2_q) begin
                        rx_vld_q <= 1'b1;
                        rx_dat_q <= rx_shift_q;
                    end
                end
            end else begin
                rx_cnt_q <= rx_cnt_q + 16'd1;
            end
        end
    end

    // ROM runs one pixel ahead so each INFER cycle sees the weights of its own pixel.
    assign rom_addr = (state_q == ST_INFER && pix_q != PIX_W'(NUM_PIXELS - 1)) ? pix_q + PIX_W'(1) : '0;

    snn_weight_rom #(
        .WEIGHT_FILE (WEIGHT_FILE)
    ) u_rom (
        .clk    (clk),
        .addr_i (rom_addr),
        .data_o (rom_data)
    );

    // Argmax with strict compare in ascending order, so ties resolve to the lowest index.
    always_comb begin
        win_idx = '0;
        win_pot = pot_q[0];
        for (int n = 1; n < NUM_NEURONS; n++) begin
            if (pot_q[n] > win_pot) begin
                win_pot = pot_q[n];
                win_idx = 4'(n);
            end
        end
    end

    // Main sequencer: collect image, integrate one pixel per cycle, latch winner, wait for TX.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RECV;
            byte_cnt_q <= '0;
            img_q      <= '0;
            pix_q      <= '0;
            led_q      <= '0;
            for (int n = 0; n < NUM_NEURONS; n++) pot_q[n] <= '0;
        end else begin
            case (state_q)
                ST_RECV: begin
                    if (rx_vld_q) begin
                        img_q[{byte_cnt_q, 3'b000} +: 8] <= rx_dat_q;
                        if (byte_cnt_q == BYTE_CNT_W'(NUM_BYTES - 1)) begin
                            byte_cnt_q <= '0;
                            pix_q      <= '0;
                            state_q    <= ST_INFER;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + BYTE_CNT_W'(1);
                        end
                    end
                end
                ST_INFER: begin
                    if (img_q[pix_q]) begin
                        for (int n = 0; n < NUM_NEURONS; n++) begin
                            pot_q[n] <= sat_add(pot_q[n], rom_data[W_WIDTH*n +: W_WIDTH]);
                        end
                    end
                    if (pix_q == PIX_W'(NUM_PIXELS - 1)) begin
                        state_q <= ST_DECIDE;
                    end else begin
                        pix_q <= pix_q + PIX_W'(1);
                    end
                end
                ST_DECIDE: begin
                    led_q   <= {4'b0000, win_idx};
                    pix_q   <= '0;
                    state_q <= ST_SEND;
                    for (int n = 0; n < NUM_NEURONS; n++) pot_q[n] <= '0;
                end
                default: begin
                    if (!tx_busy_q) state_q <= ST_RECV;
                end
            endcase
        end
    end

    // UART transmitter: start bit goes out on the same edge that latches led.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_busy_q  <= 1'b0;
            tx_line_q  <= 1'b1;
            tx_cnt_q   <= '0;
            tx_bits_q  <= '0;
            tx_frame_q <= '1;
        end else if (state_q == ST_DECIDE) begin
            tx_busy_q  <= 1'b1;
            tx_line_q  <= 1'b0;
            tx_cnt_q   <= 16'd1;
            tx_bits_q  <= 4'd9;
            tx_frame_q <= {1'b1, 8'h30 + {4'b0000, win_idx}};
        end else if (tx_busy_q) begin
            if (tx_cnt_q == BIT_CNT) begin
                tx_cnt_q <= 16'd1;
                if (tx_bits_q == 4'd0) begin
                    tx_busy_q <= 1'b0;
                end else begin
                    tx_line_q  <= tx_frame_q[0];
                    tx_frame_q <= {1'b1, tx_frame_q[8:1]};
                    tx_bits_q  <= tx_bits_q - 4'd1;
                end
            end else begin
                tx_cnt_q <= tx_cnt_q + 16'd1;
            end
        end
    end

    assign uart_tx = tx_line_q;
    assign led     = led_q;

endmodule

// File: tb/tb_snn.sv
module tb_snn;

    localparam int CPB = 4;
    localparam int H   = CPB / 2;
    // Bench drives the start edge just after posedge c0; 2 sync cycles, half bit,
    // 9 more bit periods to the stop sample, then 786 cycles to the TX start edge.
    localparam int EXP_LAT = 2 + H + 9 * CPB + 786;
    localparam int TX_BUDGET = 3000;

    logic       clk;
    logic       sys_rst_n;
    logic       uart_rx;
    logic       uart_tx;
    logic [7:0] led;

    int tests_run = 0;
    int fails = 0;
    int cyc = 0;
    int last_c0 = 0;

    int         wt [784][10];
    logic [7:0] img_bytes [98];

    snn #(
        .CLKS_PER_BIT (CPB),
        .WEIGHT_FILE  ("")
    ) dut (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .uart_rx   (uart_rx),
        .uart_tx   (uart_tx),
        .led       (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic load_rom();
        logic [79:0] word;
        int t;
        for (int p = 0; p < 784; p++) begin
            word = '0;
            for (int n = 0; n < 10; n++) begin
                t = wt[p][n];
                word[8*n +: 8] = t[7:0];
            end
            dut.u_rom.rom_mem[p] = word;
        end
    endtask

    task automatic set_rom_uniform(input int per_neuron [10]);
        for (int p = 0; p < 784; p++)
            for (int n = 0; n < 10; n++) wt[p][n] = per_neuron[n];
    endtask

    task automatic rand_rom();
        for (int p = 0; p < 784; p++)
            for (int n = 0; n < 10; n++) wt[p][n] = int'($urandom_range(0, 255)) - 128;
        load_rom();
    endtask

    task automatic rand_image();
        for (int k = 0; k < 98; k++) img_bytes[k] = 8'($urandom);
    endtask

    // Reference: integrate all pixels with clamping, then argmax with lowest index on ties.
    function automatic int model_digit();
        int pot [10];
        int bi;
        for (int n = 0; n < 10; n++) pot[n] = 0;
        for (int p = 0; p < 784; p++) begin
            if (img_bytes[p / 8][p % 8]) begin
                for (int n = 0; n < 10; n++) begin
                    pot[n] = pot[n] + wt[p][n];
                    if (pot[n] > 32767) pot[n] = 32767;
                    if (pot[n] < -32768) pot[n] = -32768;
                end
            end
        end
        bi = 0;
        for (int n = 1; n < 10; n++) if (pot[n] > pot[bi]) bi = n;
        return bi;
    endfunction

    // Called at posedge+1; returns at posedge+1 with the line idle high.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        last_c0 = cyc;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        uart_rx = stop_bit;
        repeat (CPB) @(posedge clk);
        #1;
        uart_rx = 1'b1;
    endtask

    task automatic send_image();
        for (int k = 0; k < 98; k++) send_byte(img_bytes[k], 1'b1);
    endtask

    task automatic wait_result(output logic [7:0] b, output int ecyc, output bit got, output logic stop_v);
        int k;
        got = 1'b0;
        b = '0;
        ecyc = 0;
        stop_v = 1'b0;
        k = 0;
        while (k < TX_BUDGET && !got) begin
            if (uart_tx === 1'b0) begin
                got = 1'b1;
                ecyc = cyc;
            end else begin
                @(posedge clk);
                #1;
                k++;
            end
        end
        if (got) begin
            repeat (CPB + H) @(posedge clk);
            #1;
            b[0] = uart_tx;
            for (int i = 1; i < 8; i++) begin
                repeat (CPB) @(posedge clk);
                #1;
                b[i] = uart_tx;
            end
            repeat (CPB) @(posedge clk);
            #1;
            stop_v = uart_tx;
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        tests_run++;
        if (led !== 8'h00) begin fails++; $display("FAIL reset_led_in_reset: got %h want 00", led); end
        tests_run++;
        if (uart_tx !== 1'b1) begin fails++; $display("FAIL reset_tx_in_reset: got %b want 1", uart_tx); end
        sys_rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (led !== 8'h00) begin fails++; $display("FAIL reset_led_after: got %h want 00", led); end
        tests_run++;
        if (uart_tx !== 1'b1) begin fails++; $display("FAIL reset_tx_after: got %b want 1", uart_tx); end
    endtask

    task automatic test_all_zero();
        int z [10];
        logic [7:0] b; int e; bit got; logic sv;
        for (int n = 0; n < 10; n++) z[n] = 0;
        set_rom_uniform(z);
        load_rom();
        for (int k = 0; k < 98; k++) img_bytes[k] = 8'h00;
        send_image();
        wait_result(b, e, got, sv);
        tests_run++;
        if (!got) begin fails++; $display("FAIL zero_tx_seen: got none want frame"); end
        tests_run++;
        if (b !== 8'h30) begin fails++; $display("FAIL zero_tx_byte: got %h want 30", b); end
        tests_run++;
        if (led !== 8'h00) begin fails++; $display("FAIL zero_led: got %h want 00", led); end
        tests_run++;
        if (sv !== 1'b1) begin fails++; $display("FAIL zero_stop_bit: got %b want 1", sv); end
    endtask

    task automatic test_neuron7_latency();
        int w [10];
        logic [7:0] b; int e; bit got; logic sv;
        for (int n = 0; n < 10; n++) w[n] = (n == 7) ? 1 : 0;
        set_rom_uniform(w);
        load_rom();
        for (int k = 0; k < 98; k++) img_bytes[k] = 8'hFF;
        send_image();
        wait_result(b, e, got, sv);
        tests_run++;
        if (b !== 8'h37) begin fails++; $display("FAIL n7_tx_byte: got %h want 37", b); end
        tests_run++;
        if (led !== 8'h07) begin fails++; $display("FAIL n7_led: got %h want 07", led); end
        tests_run++;
        if (!got || (e - last_c0) != EXP_LAT) begin
            fails++;
            $display("FAIL n7_latency: got %0d want %0d", e - last_c0, EXP_LAT);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b; int e; bit got; logic sv; int exp_d;
        rand_rom();
        for (int k = 0; k < 50; k++) send_byte(8'($urandom), 1'b1);
        sys_rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        tests_run++;
        if (led !== 8'h00) begin fails++; $display("FAIL rstmid_led_in_reset: got %h want 00", led); end
        tests_run++;
        if (uart_tx !== 1'b1) begin fails++; $display("FAIL rstmid_tx_in_reset: got %b want 1", uart_tx); end
        sys_rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (led !== 8'h00) begin fails++; $display("FAIL rstmid_led_after: got %h want 00", led); end
        rand_image();
        exp_d = model_digit();
        send_image();
        wait_result(b, e, got, sv);
        tests_run++;
        if (!got || b !== 8'(8'h30 + exp_d)) begin fails++; $display("FAIL rstmid_tx_byte: got %h want %h", b, 8'(8'h30 + exp_d)); end
        tests_run++;
        if (led !== 8'(exp_d)) begin fails++; $display("FAIL rstmid_led: got %h want %h", led, 8'(exp_d)); end
    endtask

    task automatic test_pixel8();
        logic [7:0] b; int e; bit got; logic sv;
        for (int p = 0; p < 784; p++)
            for (int n = 0; n < 10; n++) wt[p][n] = 0;
        wt[8][3] = 1;
        wt[0][5] = 1;
        load_rom();
        for (int k = 0; k < 98; k++) img_bytes[k] = 8'h00;
        img_bytes[1] = 8'h01;
        send_image();
        wait_result(b, e, got, sv);
        tests_run++;
        if (!got || b !== 8'h33) begin fails++; $display("FAIL pix8_tx_byte: got %h want 33", b); end
        tests_run++;
        if (led !== 8'h03) begin fails++; $display("FAIL pix8_led: got %h want 03", led); end
    endtask

    task automatic test_saturation();
        int w [10];
        logic [7:0] b; int e; bit got; logic sv;
        // Neurons 2 and 6 both clamp at +32767 (tie -> 2); neuron 0 stays at 31360.
        for (int n = 0; n < 10; n++) w[n] = 0;
        w[0] = 40; w[2] = 127; w[6] = 127; w[4] = -128;
        set_rom_uniform(w);
        load_rom();
        for (int k = 0; k < 98; k++) img_bytes[k] = 8'hFF;
        send_image();
        wait_result(b, e, got, sv);
        tests_run++;
        if (!got || b !== 8'h32) begin fails++; $display("FAIL sat_tx_byte: got %h want 32", b); end
        tests_run++;
        if (led !== 8'h02) begin fails++; $display("FAIL sat_led: got %h want 02", led); end
    endtask

    task automatic test_random();
        logic [7:0] b; int e; bit got; logic sv; int exp_d;
        for (int it = 0; it < 2; it++) begin
            rand_rom();
            rand_image();
            exp_d = model_digit();
            send_image();
            wait_result(b, e, got, sv);
            tests_run++;
            if (!got || b !== 8'(8'h30 + exp_d)) begin fails++; $display("FAIL rand%0d_tx_byte: got %h want %h", it, b, 8'(8'h30 + exp_d)); end
            tests_run++;
            if (led !== 8'(exp_d)) begin fails++; $display("FAIL rand%0d_led: got %h want %h", it, led, 8'(exp_d)); end
        end
    endtask

    task automatic test_framing();
        logic [7:0] b; int e; bit got; logic sv; int exp_d;
        rand_rom();
        rand_image();
        exp_d = model_digit();
        for (int k = 0; k < 40; k++) send_byte(img_bytes[k], 1'b1);
        send_byte(8'($urandom), 1'b0);
        repeat (2 * CPB) @(posedge clk);
        #1;
        for (int k = 40; k < 98; k++) send_byte(img_bytes[k], 1'b1);
        wait_result(b, e, got, sv);
        tests_run++;
        if (!got || b !== 8'(8'h30 + exp_d)) begin fails++; $display("FAIL frame_tx_byte: got %h want %h", b, 8'(8'h30 + exp_d)); end
        tests_run++;
        if (led !== 8'(exp_d)) begin fails++; $display("FAIL frame_led: got %h want %h", led, 8'(exp_d)); end
        tests_run++;
        if (!got || (e - last_c0) != EXP_LAT) begin fails++; $display("FAIL frame_latency: got %0d want %0d", e - last_c0, EXP_LAT); end
    endtask

    task automatic test_infer_ignored();
        logic [7:0] b; int e; bit got; logic sv; int exp_d; bit quiet;
        rand_rom();
        rand_image();
        exp_d = model_digit();
        send_image();
        for (int k = 0; k < 5; k++) send_byte(8'($urandom), 1'b1);
        wait_result(b, e, got, sv);
        tests_run++;
        if (!got || b !== 8'(8'h30 + exp_d)) begin fails++; $display("FAIL infer1_tx_byte: got %h want %h", b, 8'(8'h30 + exp_d)); end
        rand_image();
        exp_d = model_digit();
        for (int k = 0; k < 97; k++) send_byte(img_bytes[k], 1'b1);
        quiet = 1'b1;
        for (int c = 0; c < 900; c++) begin
            @(posedge clk);
            #1;
            if (uart_tx !== 1'b1) quiet = 1'b0;
        end
        tests_run++;
        if (!quiet) begin fails++; $display("FAIL infer_early_result: got tx activity want idle before byte 98"); end
        send_byte(img_bytes[97], 1'b1);
        wait_result(b, e, got, sv);
        tests_run++;
        if (!got || b !== 8'(8'h30 + exp_d)) begin fails++; $display("FAIL infer2_tx_byte: got %h want %h", b, 8'(8'h30 + exp_d)); end
        tests_run++;
        if (led !== 8'(exp_d)) begin fails++; $display("FAIL infer2_led: got %h want %h", led, 8'(exp_d)); end
    endtask

    initial begin
        sys_rst_n = 1'b1;
        uart_rx   = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        test_reset();
        test_all_zero();
        test_neuron7_latency();
        test_reset_mid();
        test_pixel8();
        test_saturation();
        test_random();
        test_framing();
        test_infer_ignored();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
